// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
//   - width codes carried on req_width
//   - FSM state encoding (also exported on the debug port)
//   - store_merge / load_extract: pure lane functions, little-endian,
//     byte lane k = bits [8k+7:8k], selected by the low address bits.
package dm_pkg;

    localparam logic [2:0] W_WORD  = 3'd0;
    localparam logic [2:0] W_HALFU = 3'd1;
    localparam logic [2:0] W_HALFS = 3'd2;
    localparam logic [2:0] W_BYTEU = 3'd3;
    localparam logic [2:0] W_BYTES = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Insert right-aligned wdata into the lane picked by width/offset,
    // leaving the other lanes of old_word untouched.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  width,
                                                input logic [1:0]  off);
        logic [31:0] w;
        w = old_word;
        case (width)
            W_WORD:           w = wdata;
            W_HALFU, W_HALFS: w[{off[1], 4'b0000} +: 16] = wdata[15:0];
            W_BYTEU, W_BYTES: w[{off, 3'b000} +: 8] = wdata[7:0];
            default:          w = old_word;
        endcase
        return w;
    endfunction

    // Pull the selected lane out of a word and zero/sign extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  width,
                                                 input logic [1:0]  off);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = word[{off[1], 4'b0000} +: 16];
        b = word[{off, 3'b000} +: 8];
        case (width)
            W_WORD:  r = word;
            W_HALFU: r = {16'h0000, h};
            W_HALFS: r = {{16{h[15]}}, h};
            W_BYTEU: r = {24'h000000, b};
            W_BYTES: r = {{24{b[7]}}, b};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store port between the core memory stage and dm_responder.
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; valid must not depend on ready, and the payload is only
// meaningful while valid is high. Request and response channels are
// independent; trace_* is an output-only pulse channel (no ready).
//   slave  : responder side (takes requests, drives responses and trace)
//   master : core side
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_width;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    modport slave (
        input  req_valid, req_we, req_width, req_addr, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output trace_valid, trace_pc, trace_addr, trace_data
    );

    modport master (
        output req_valid, req_we, req_width, req_addr, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  trace_valid, trace_pc, trace_addr, trace_data
    );
endinterface

// File: rtl/dm_lane_unit.sv
// Combinational lane logic for one access.
//   old_word : current contents of the addressed word
//   wdata    : right-aligned store data
//   width    : access width code
//   addr     : full byte address
//   merged   : word to write back on a store
//   rdata    : extended load result
//   fault    : illegal width, misaligned, or beyond DEPTH_WORDS
module dm_lane_unit
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072
) (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [2:0]  width,
    input  logic [31:0] addr,
    output logic [31:0] merged,
    output logic [31:0] rdata,
    output logic        fault
);

    logic bad_width;
    logic bad_align;
    logic bad_range;

    always_comb begin
        bad_width = (width > W_BYTES);
        bad_align = (((width == W_HALFU) || (width == W_HALFS)) && addr[0])
                  || ((width == W_WORD) && (addr[1:0] != 2'b00));
        bad_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        fault     = bad_width || bad_align || bad_range;
        merged    = store_merge(old_word, wdata, width, addr[1:0]);
        rdata     = load_extract(old_word, width, addr[1:0]);
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store at a time with
// WAIT_CYCLES extra cycles between acceptance and response.
//   clk       : rising-edge clock
//   reset     : synchronous, active-low; clears memory, FSM and outputs
//   dm        : request/response/trace channels (slave side)
//   dbg_state : current FSM state
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  dm,
    output state_e         dbg_state
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  width_q, width_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        trace_valid_q, trace_valid_d;
    logic [31:0] trace_pc_q, trace_pc_d;
    logic [31:0] trace_addr_q, trace_addr_d;
    logic [31:0] trace_data_q, trace_data_d;

    // Word storage has no reset; a per-word written flag is cleared instead,
    // so a word never written since reset reads as zero.
    logic [31:0]            mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] vld_q, vld_d;

    // With WAIT_CYCLES==0 the access happens on the acceptance edge, before
    // the request is latched, so the lane unit looks at the live request
    // while IDLE and at the latched copy otherwise.
    logic             cur_we;
    logic [2:0]       cur_width;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [31:0]      cur_pc;
    logic [IDX_W-1:0] widx;
    logic [31:0]      rd_word;
    logic [31:0]      merged;
    logic [31:0]      ext;
    logic             fault;
    logic             do_access;
    logic             mem_we;

    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = dm.req_we;
            cur_width = dm.req_width;
            cur_addr  = dm.req_addr;
            cur_wdata = dm.req_wdata;
            cur_pc    = dm.req_pc;
        end else begin
            cur_we    = we_q;
            cur_width = width_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_pc    = pc_q;
        end
        widx    = cur_addr[IDX_W+1:2];
        rd_word = ((32'(widx) < 32'(DEPTH_WORDS)) && vld_q[widx]) ? mem_q[widx] : '0;
    end

    dm_lane_unit #(.DEPTH_WORDS(DEPTH_WORDS)) u_lane (
        .old_word (rd_word),
        .wdata    (cur_wdata),
        .width    (cur_width),
        .addr     (cur_addr),
        .merged   (merged),
        .rdata    (ext),
        .fault    (fault)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        width_d       = width_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        pc_d          = pc_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        trace_valid_d = 1'b0;
        trace_pc_d    = trace_pc_q;
        trace_addr_d  = trace_addr_q;
        trace_data_d  = trace_data_q;
        vld_d         = vld_q;
        do_access     = 1'b0;
        mem_we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm.req_valid) begin
                    we_d    = dm.req_we;
                    width_d = dm.req_width;
                    addr_d  = dm.req_addr;
                    wdata_d = dm.req_wdata;
                    pc_d    = dm.req_pc;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (dm.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            err_d   = fault;
            rdata_d = (fault || cur_we) ? 32'h0 : ext;
            if (cur_we && !fault) begin
                mem_we        = 1'b1;
                vld_d[widx]   = 1'b1;
                trace_valid_d = 1'b1;
                trace_pc_d    = cur_pc;
                trace_addr_d  = {cur_addr[31:2], 2'b00};
                trace_data_d  = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            width_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            pc_q          <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
            vld_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            width_q       <= width_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            pc_q          <= pc_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
            vld_q         <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem_q[widx] <= merged;
        end
    end

    assign dm.req_ready   = (state_q == IDLE) && reset;
    assign dm.rsp_valid   = (state_q == RESP);
    assign dm.rsp_rdata   = rdata_q;
    assign dm.rsp_err     = err_q;
    assign dm.trace_valid = trace_valid_q;
    assign dm.trace_pc    = trace_pc_q;
    assign dm.trace_addr  = trace_addr_q;
    assign dm.trace_data  = trace_data_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;
    import dm_pkg::*;

    localparam int DEPTH = 3072;

    logic   clk;
    logic   reset;
    state_e st_a;
    state_e st_b;

    dm_responder_if bus_a ();
    dm_responder_if bus_b ();

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .dm(bus_a), .dbg_state(st_a)
    );
    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .dm(bus_b), .dbg_state(st_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    // which DUT the driver tasks talk to
    bit   cur_sel = 1'b0;
    logic cur_req_ready, cur_rsp_valid, cur_rsp_err, cur_trace_valid;
    logic [31:0] cur_rsp_rdata;
    assign cur_req_ready   = cur_sel ? bus_b.req_ready   : bus_a.req_ready;
    assign cur_rsp_valid   = cur_sel ? bus_b.rsp_valid   : bus_a.rsp_valid;
    assign cur_rsp_err     = cur_sel ? bus_b.rsp_err     : bus_a.rsp_err;
    assign cur_rsp_rdata   = cur_sel ? bus_b.rsp_rdata   : bus_a.rsp_rdata;
    assign cur_trace_valid = cur_sel ? bus_b.trace_valid : bus_a.trace_valid;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (cur_sel) bus_b.req_valid = v;
        else         bus_a.req_valid = v;
    endtask

    task automatic set_rsp_ready(input logic v);
        if (cur_sel) bus_b.rsp_ready = v;
        else         bus_a.rsp_ready = v;
    endtask

    task automatic drive_fields(input logic we, input logic [2:0] width,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] pc);
        bus_a.req_we = we;  bus_a.req_width = width;  bus_a.req_addr = addr;
        bus_a.req_wdata = wdata;  bus_a.req_pc = pc;
        bus_b.req_we = we;  bus_b.req_width = width;  bus_b.req_addr = addr;
        bus_b.req_wdata = wdata;  bus_b.req_pc = pc;
    endtask

    // Called just after the acceptance edge: counts negedges until rsp_valid,
    // counts trace pulses, then completes the response handshake.
    task automatic finish_rsp(output logic [31:0] rdata, output logic err,
                              output int lat, output int ntr);
        lat = 0;
        ntr = 0;
        rdata = '0;
        err = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (cur_trace_valid) ntr++;
        end while (!cur_rsp_valid && lat < 20);
        if (!cur_rsp_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, expected within 16", lat);
            return;
        end
        rdata = cur_rsp_rdata;
        err   = cur_rsp_err;
        set_rsp_ready(1'b1);
        @(posedge clk);
        #1 set_rsp_ready(1'b0);
        @(negedge clk);
        if (cur_trace_valid) ntr++;
    endtask

    task automatic do_req(input logic we, input logic [2:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int ntr);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cur_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cur_req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL req_ready_timeout: got req_ready 0 for %0d cycles, expected 1", guard);
            rdata = '0; err = 1'b0; lat = 0; ntr = 0;
            return;
        end
        drive_fields(we, width, addr, wdata, pc);
        set_valid(1'b1);
        @(posedge clk);
        #1 set_valid(1'b0);
        finish_rsp(rdata, err, lat, ntr);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_tr;
        logic [31:0] exp_tdata;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_rd;
        int          lat;
        int          ntr;
        int          guard;

        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h1000, 32'h0000_0000, 1'b0, 0, 32'h0};
        vecs[1]  = '{1'b1, 3'd0, 32'h0000_0010, 32'h1234_5678, 32'h1004, 32'h0000_0000, 1'b0, 1, 32'h1234_5678};
        vecs[2]  = '{1'b1, 3'd3, 32'h0000_0011, 32'h0000_0080, 32'h1008, 32'h0000_0000, 1'b0, 1, 32'h1234_8078};
        vecs[3]  = '{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'h100C, 32'h1234_8078, 1'b0, 0, 32'h0};
        vecs[4]  = '{1'b0, 3'd4, 32'h0000_0011, 32'h0,         32'h1010, 32'hFFFF_FF80, 1'b0, 0, 32'h0};
        vecs[5]  = '{1'b0, 3'd3, 32'h0000_0013, 32'h0,         32'h1014, 32'h0000_0012, 1'b0, 0, 32'h0};
        vecs[6]  = '{1'b0, 3'd4, 32'h0000_0010, 32'h0,         32'h1018, 32'h0000_0078, 1'b0, 0, 32'h0};
        vecs[7]  = '{1'b1, 3'd1, 32'h0000_0022, 32'h0000_BEEF, 32'h3004, 32'h0000_0000, 1'b0, 1, 32'hBEEF_0000};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_0022, 32'h0,         32'h3008, 32'hFFFF_BEEF, 1'b0, 0, 32'h0};
        vecs[9]  = '{1'b0, 3'd1, 32'h0000_0022, 32'h0,         32'h300C, 32'h0000_BEEF, 1'b0, 0, 32'h0};
        vecs[10] = '{1'b1, 3'd0, 32'h0000_0000, 32'hA5A5_A5A5, 32'h2000, 32'h0000_0000, 1'b0, 1, 32'hA5A5_A5A5};
        vecs[11] = '{1'b0, 3'd0, 32'h0000_0002, 32'h0,         32'h2004, 32'h0000_0000, 1'b1, 0, 32'h0};
        vecs[12] = '{1'b1, 3'd1, 32'h0000_0001, 32'h0000_1111, 32'h2008, 32'h0000_0000, 1'b1, 0, 32'h0};
        vecs[13] = '{1'b1, 3'd6, 32'h0000_0000, 32'hFFFF_FFFF, 32'h200C, 32'h0000_0000, 1'b1, 0, 32'h0};
        vecs[14] = '{1'b1, 3'd0, 32'(4*DEPTH),  32'h7777_7777, 32'h2010, 32'h0000_0000, 1'b1, 0, 32'h0};
        vecs[15] = '{1'b0, 3'd0, 32'h0000_0000, 32'h0,         32'h2014, 32'hA5A5_A5A5, 1'b0, 0, 32'h0};
        vecs[16] = '{1'b0, 3'd0, 32'(4*DEPTH-4), 32'h0,        32'h2018, 32'h0000_0000, 1'b0, 0, 32'h0};

        reset = 1'b0;
        bus_a.req_valid = 1'b0;  bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = 1'b0;  bus_b.rsp_ready = 1'b0;
        drive_fields(1'b0, 3'd0, 32'h0, 32'h0, 32'h0);

        // reset held low for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",   32'(bus_a.req_ready), 32'd0);
        check("rst_rsp_valid",   32'(bus_a.rsp_valid), 32'd0);
        check("rst_rsp_err",     32'(bus_a.rsp_err), 32'd0);
        check("rst_rsp_rdata",   bus_a.rsp_rdata, 32'h0);
        check("rst_trace_valid", 32'(bus_a.trace_valid), 32'd0);
        check("rst_trace_pc",    bus_a.trace_pc, 32'h0);
        check("rst_trace_addr",  bus_a.trace_addr, 32'h0);
        check("rst_trace_data",  bus_a.trace_data, 32'h0);
        check("rst_state",       32'(st_a), 32'(IDLE));
        reset = 1'b1;

        // table-driven vectors on the WAIT_CYCLES=1 instance
        cur_sel = 1'b0;
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(vecs[i].exp_rdata);
            do_req(vecs[i].we, vecs[i].width, vecs[i].addr, vecs[i].wdata, vecs[i].pc,
                   rd, er, lat, ntr);
            exp_rd = exp_q.pop_front();
            check($sformatf("v%0d_rdata", i), rd, exp_rd);
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("v%0d_trace_pulses", i), 32'(ntr), 32'(vecs[i].exp_tr));
            if (vecs[i].exp_tr == 1) begin
                check($sformatf("v%0d_trace_pc", i), bus_a.trace_pc, vecs[i].pc);
                check($sformatf("v%0d_trace_addr", i), bus_a.trace_addr, vecs[i].addr & ~32'h3);
                check($sformatf("v%0d_trace_data", i), bus_a.trace_data, vecs[i].exp_tdata);
            end
        end

        // response back-pressure: hold rsp_ready low for 5 cycles
        @(negedge clk);
        drive_fields(1'b0, 3'd0, 32'h10, 32'h0, 32'h4000);
        set_valid(1'b1);
        @(posedge clk);
        #1 set_valid(1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus_a.rsp_valid && guard < 20);
        for (int k = 0; k < 5; k++) begin
            check("stall_rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
            check("stall_rdata", bus_a.rsp_rdata, 32'h1234_8078);
            check("stall_err", 32'(bus_a.rsp_err), 32'd0);
            check("stall_req_ready", 32'(bus_a.req_ready), 32'd0);
            @(negedge clk);
        end
        set_rsp_ready(1'b1);
        @(posedge clk);
        #1 set_rsp_ready(1'b0);
        @(negedge clk);
        check("bubble_req_ready", 32'(bus_a.req_ready), 32'd1);
        drive_fields(1'b0, 3'd1, 32'h22, 32'h0, 32'h4004);
        set_valid(1'b1);
        @(posedge clk);
        #1 set_valid(1'b0);
        check("bubble_accepted", 32'(st_a), 32'(WAIT));
        finish_rsp(rd, er, lat, ntr);
        check("bubble_rdata", rd, 32'h0000_BEEF);
        check("bubble_latency", 32'(lat), 32'd2);

        // reset while a store sits in WAIT
        @(negedge clk);
        drive_fields(1'b1, 3'd0, 32'h40, 32'hDEAD_BEEF, 32'h5000);
        set_valid(1'b1);
        @(posedge clk);
        #1 set_valid(1'b0);
        check("inflight_wait", 32'(st_a), 32'(WAIT));
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("inflight_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("inflight_trace_valid", 32'(bus_a.trace_valid), 32'd0);
        check("inflight_state", 32'(st_a), 32'(IDLE));
        check("inflight_req_ready", 32'(bus_a.req_ready), 32'd0);
        reset = 1'b1;
        do_req(1'b0, 3'd0, 32'h40, 32'h0, 32'h5004, rd, er, lat, ntr);
        check("post_reset_rdata_40", rd, 32'h0);
        check("post_reset_err_40", 32'(er), 32'd0);
        do_req(1'b0, 3'd0, 32'h10, 32'h0, 32'h5008, rd, er, lat, ntr);
        check("post_reset_rdata_10", rd, 32'h0);

        // zero-wait instance
        cur_sel = 1'b1;
        do_req(1'b1, 3'd0, 32'h4, 32'h0000_0055, 32'h6000, rd, er, lat, ntr);
        check("w0_store_latency", 32'(lat), 32'd1);
        check("w0_store_trace", 32'(ntr), 32'd1);
        check("w0_trace_data", bus_b.trace_data, 32'h0000_0055);
        do_req(1'b0, 3'd4, 32'h4, 32'h0, 32'h6004, rd, er, lat, ntr);
        check("w0_load_latency", 32'(lat), 32'd1);
        check("w0_load_rdata", rd, 32'h0000_0055);
        do_req(1'b0, 3'd2, 32'h5, 32'h0, 32'h6008, rd, er, lat, ntr);
        check("w0_misaligned_err", 32'(er), 32'd1);
        check("w0_misaligned_rdata", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder serving the CPU's load/store port over a valid/ready request/response handshake with configurable wait states.
- Performs sub-word store merge and load extract with sign/zero extension.
- Reports misaligned, out-of-range and illegal-width accesses, and emits a one-cycle write-commit trace record.
- Sits between the core's memory stage and the word-organised data RAM; the multi-cycle pipelined core needs this in place of a zero-latency memory.

Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 1: extra cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  3  0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed; 5-7 illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_pc  in  32  PC of the issuing instruction (trace only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access faulted.
- trace_valid  out  1  one-cycle pulse on store commit.
- trace_pc  out  32  PC of the committed store.
- trace_addr  out  32  word-aligned address of the committed store.
- trace_data  out  32  full merged word written.

Behaviour:
- FSM states: IDLE, WAIT, RESP. req_ready = (state==IDLE) && reset; it is 0 while reset is low.
- Reset (reset==0 at an edge):
  - state goes to IDLE; all memory words are cleared to 0.
  - rsp_valid, rsp_err, rsp_rdata, trace_valid, trace_pc, trace_addr and trace_data all go to 0.
  - An in-flight request is dropped with no response.
- Acceptance: at an edge with req_valid && req_ready, latch we/width/addr/wdata/pc.
  - Next state is WAIT with the counter loaded to WAIT_CYCLES-1, or RESP if WAIT_CYCLES==0.
- WAIT: the counter decrements each cycle. At the edge where the counter is 0, go to RESP. At that same edge, perform the access: commit the store or sample the load.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - The edge with rsp_ready=1 returns the FSM to IDLE, so back-to-back requests see one idle bubble.
  - Only one request is outstanding at a time.
- Fault conditions (checked on latched fields):
  - width 5-7;
  - half access with addr[0]!=0;
  - word access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
- On fault: no memory write, no trace, rsp_err=1, rsp_rdata=0.
- Lanes are little-endian: byte lane k = bits [8k+7:8k], selected by addr[1:0].
- Store, width 0: write the full word.
- Store, width 1/2: wdata[15:0] goes to half lane addr[1]; other lanes are preserved.
- Store, width 3/4: wdata[7:0] goes to byte lane addr[1:0]; other lanes are preserved.
- Load: extract the selected lane. Widths 1 and 3 zero-extend; widths 2 and 4 sign-extend; width 0 returns the word.
- Trace: trace_valid is high for exactly the first cycle of RESP on a successful store, with the latched pc, addr & ~3 and the merged word. trace_* are held between pulses.
- Reset takes priority over every other event in the same cycle.

Decomposition:
- Package dm_pkg holds:
  - width codes W_WORD=0, W_HALFU=1, W_HALFS=2, W_BYTEU=3, W_BYTES=4;
  - FSM state enum;
  - pure functions store_merge(old, wdata, width, addr[1:0]) and load_extract(word, width, addr[1:0]).
- One combinational sub-module, dm_lane_unit, wraps the merge/extract/fault check. The FSM, counter, trace registers and memory array stay in dm_responder.

Test Plan (WAIT_CYCLES=1 unless stated):
- Reset low 2 cycles, release; lw @0x0 accepted at edge t -> rsp_valid at t+2, rdata 0x00000000, err 0.
- sw 0x12345678 @0x10, then:
  - sb 0x80 @0x11, then lw @0x10 -> 0x12348078;
  - lb @0x11 -> 0xFFFFFF80;
  - lbu @0x13 -> 0x00000012.
- sh 0xBEEF @0x22 with pc 0x3004 -> trace_valid single pulse, trace_pc 0x3004, trace_addr 0x20, trace_data 0xBEEF0000; lh @0x22 -> 0xFFFFBEEF; lhu @0x22 -> 0x0000BEEF.
- Each of the following -> rsp_err 1, rdata 0, no trace_valid, word @0x0 unchanged:
  - lw @0x2;
  - sh @0x1;
  - width=6 @0x0;
  - sw @(4*DEPTH_WORDS).
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rdata, err stable and req_ready 0 throughout; raise rsp_ready -> next request accepted one cycle later. Rerun with WAIT_CYCLES=0 -> response 1 cycle after acceptance.
- Reset driven low while a sw is in WAIT -> next cycle rsp_valid 0, trace_valid 0, state IDLE; after release, lw of that address returns 0.
